// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks every register through the register file's
// combinational read port and streams each value over a valid/ready beat
// interface. Busy stalls the core while the dump owns the read port.
// Optional build macro REG_DUMP_CHECKSUM_EN appends a final XOR-checksum beat.
module reg_dump_reader #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Abort,
  output logic [D-1:0] RdAddr,
  input  logic [W-1:0] RdData,
  output logic [W-1:0] DumpData,
  output logic [D-1:0] DumpAddr,
  output logic         DumpLast,
  output logic         DumpValid,
  input  logic         DumpReady,
  output logic         Busy,
  output logic         Done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_SEND   = 3'd2;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [2:0] S_SUM    = 3'd3;
`endif
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [D-1:0] LAST_PTR = '1;

  logic [2:0]   state;
  logic [D-1:0] ptr;
  logic         ptr_last;
  logic         hs;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [W-1:0] csum;
`endif

  assign ptr_last = (ptr == LAST_PTR);
  assign hs       = DumpValid && DumpReady;

  // Read port and status decode straight from state; all zero in IDLE/reset
  always_comb begin
    RdAddr = (state == S_IDLE) ? '0 : ptr;
`ifdef REG_DUMP_CHECKSUM_EN
    Busy   = (state == S_READ) || (state == S_SEND) || (state == S_SUM);
`else
    Busy   = (state == S_READ) || (state == S_SEND);
`endif
    Done   = (state == S_FINISH);
  end

  // Dump sequencer: one READ cycle captures a register, SEND holds the beat
  // until the sink takes it; Abort drops everything without a Done pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      DumpData  <= '0;
      DumpAddr  <= '0;
      DumpLast  <= 1'b0;
      DumpValid <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!Abort && Start) begin
            state <= S_READ;
            ptr   <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        S_READ: begin
          if (Abort) begin
            state     <= S_IDLE;
            ptr       <= '0;
            DumpValid <= 1'b0;
          end else begin
            DumpData  <= RdData;
            DumpAddr  <= ptr;
            DumpValid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            DumpLast  <= 1'b0;
            csum      <= csum ^ RdData;
`else
            DumpLast  <= ptr_last;
`endif
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (Abort) begin
            state     <= S_IDLE;
            ptr       <= '0;
            DumpValid <= 1'b0;
          end else if (hs) begin
            DumpValid <= 1'b0;
            if (ptr_last) begin
`ifdef REG_DUMP_CHECKSUM_EN
              state <= S_SUM;
`else
              state <= S_FINISH;
`endif
            end else begin
              ptr   <= ptr + 1'b1;
              state <= S_READ;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        // First SUM cycle loads the checksum beat, then it is held like SEND
        S_SUM: begin
          if (Abort) begin
            state     <= S_IDLE;
            ptr       <= '0;
            DumpValid <= 1'b0;
          end else if (!DumpValid) begin
            DumpData  <= csum;
            DumpAddr  <= '0;
            DumpLast  <= 1'b1;
            DumpValid <= 1'b1;
          end else if (DumpReady) begin
            DumpValid <= 1'b0;
            state     <= S_FINISH;
          end
        end
`endif
        S_FINISH: begin
          state <= S_IDLE;
          ptr   <= '0;
        end
        default: begin
          state     <= S_IDLE;
          ptr       <= '0;
          DumpValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Debug/readback engine for the processor's register file.
- Walks every register through the register file's single combinational read port (address out, data in).
- Streams each value out over a valid/ready handshake to the test harness or debug UART bridge.
- Asserts Busy while it owns the read port, so the core is stalled and no register writes occur during a dump.

Parameters:
- W, 8, data path width (matches register file width).
- D, 4, register pointer width; 2**D registers are dumped.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- Abort  input  1  synchronous cancel; highest priority after Reset.
- RdAddr  output  D  read address to register file read port.
- RdData  input  W  combinational read data returned for RdAddr.
- DumpData  output  W  registered beat data.
- DumpAddr  output  D  register index of current beat.
- DumpLast  output  1  marks final beat of a dump.
- DumpValid  output  1  beat valid.
- DumpReady  input  1  sink accepts beat when DumpValid&&DumpReady.
- Busy  output  1  dump in progress; core must stall while high.
- Done  output  1  one-cycle pulse after final beat accepted.

Behaviour:
- Reset (async, any state): state=IDLE, Ptr=0; all outputs 0 (RdAddr, DumpData, DumpAddr, DumpLast, DumpValid, Busy, Done), checksum=0.
- States: IDLE, READ, SEND, SUM (feature only), FINISH.
- IDLE: Busy=0. Start=1 -> READ, Ptr=0, checksum cleared.
- READ (1 cycle): RdAddr=Ptr. At the clock edge: DumpData<=RdData, DumpAddr<=Ptr, DumpValid<=1, DumpLast<=(Ptr==2**D-1 and feature off), checksum^=RdData. Go to SEND.
- SEND: DumpData/DumpAddr/DumpLast held stable while DumpValid=1 and DumpReady=0. On handshake, DumpValid<=0, then:
  - Ptr==2**D-1: go to SUM if feature on, else FINISH.
  - Otherwise: Ptr<=Ptr+1, go to READ.
- Throughput: 1 beat per 2 cycles minimum. Start-to-first-DumpValid latency is 2 cycles.
- FINISH: Done=1 for exactly one cycle, Busy=0, then IDLE.
- Busy=1 in READ, SEND and SUM only; it rises the cycle after Start is sampled.
- RdAddr is only meaningful in READ; it holds Ptr in other states and is 0 in IDLE.
- Start outside IDLE: ignored.
- Abort in READ/SEND/SUM: next state IDLE, DumpValid dropped without handshake, Done not pulsed, Ptr=0. Abort in IDLE/FINISH: no effect (FINISH still pulses Done).
- Start and Abort together in IDLE: Abort wins, stay IDLE.
- Ptr is D bits; the final-register compare prevents wrap. No beat is emitted twice.
- Reset mid-dump: immediate return to reset values. The sink must discard a partial dump.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined: after register 2**D-1 is accepted, state SUM emits one extra beat with DumpData = XOR of all 2**D dumped values, DumpAddr=0, DumpLast=1. Same hold rules as SEND. Handshake -> FINISH. Register 2**D-1's beat then has DumpLast=0.
- Undefined: no SUM state or checksum logic; DumpLast=1 on register 2**D-1's beat.

Test Plan:
- Reset, preload reg file reg i = 8'h10+i, pulse Start, DumpReady=1 constantly -> 16 beats, addr 0..15, data 8'h10..8'h1F, DumpLast only on addr 15, Done pulse 1 cycle after, 33 cycles Start-to-Done.
- Same preload, DumpReady toggled pseudo-randomly -> DumpData/DumpAddr stable across every stalled cycle, no beat duplicated or dropped.
- Abort asserted while DumpAddr=5 and DumpReady=0 -> DumpValid=0 and Busy=0 next cycle, no Done; a new Start restarts at addr 0.
- Assert Reset async mid-SEND (between clock edges) -> all outputs 0 immediately, state IDLE.
- Start pulsed again while Busy -> ignored; exactly 16 beats.
- With REG_DUMP_CHECKSUM_EN, regs = 8'h10+i -> 17th beat DumpData=8'h00 (XOR of 0x10..0x1F), DumpAddr=0, DumpLast=1; regs all 8'hA5 except reg 3=8'h00 -> checksum 8'hA5.
